seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Multi-cycle, parametrised add/subtract unit for WIDTH-bit operands.
- Processes CHUNK bits per clock through one CHUNK-bit ripple stage, passing the carry between cycles in a register.
- Trades latency for a short carry chain, so wide adders (16/32 bits) close timing on lab boards.
- Valid/ready handshakes on both input and output, so it can sit between a switch/register front end and an LED/display back end.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be ≥ 1 and a multiple of CHUNK.
- CHUNK, 4: bits added per clock cycle. Must be between 1 and WIDTH.
- NCHUNK (derived, localparam): WIDTH/CHUNK, the number of compute cycles.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- carry_out  output  1  carry out of the MSB. In subtract mode this is the no-borrow flag: 1 iff A ≥ B unsigned.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset, asserted asynchronously while rst_n=0:
  - state=IDLE.
  - in_ready=1, out_valid=0.
  - sum=0, carry_out=0, overflow=0.
  - Internal operand, carry and chunk-index registers = 0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1:
    - Latch a into the A register.
    - Latch b into the B register, XORed with {WIDTH{sub}}.
    - Set the carry register to sub.
    - Clear the chunk index k to 0.
    - Go to RUN.
  - If in_valid=0, stay in IDLE.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge adds A[k*CHUNK +: CHUNK] + B'[k*CHUNK +: CHUNK] + carry.
  - Write the CHUNK-bit result into sum[k*CHUNK +: CHUNK] and update the carry register.
  - When k=NCHUNK−1, this edge also does the following:
    - Set carry_out to the final carry.
    - Set overflow to the carry into the MSB XOR the carry out of the MSB. Equivalently, overflow=1 iff A[MSB]==B'[MSB] and sum[MSB]!=A[MSB].
    - Go to DONE.
  - Otherwise increment k.
- DONE:
  - out_valid=1.
  - sum, carry_out and overflow are held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE and set out_valid=0. sum and the flags keep their values until the next operation overwrites them.
- Latency:
  - The accept edge is E.
  - out_valid is high from the edge E+NCHUNK, i.e. NCHUNK cycles after acceptance.
  - Throughput is one operation per NCHUNK+2 cycles when out_ready is held at 1.
- Inputs a, b and sub are sampled only at the accept edge. Changes to them during RUN or DONE have no effect.
- in_valid asserted in RUN or DONE is ignored; the upstream holds it until in_ready=1.
- No overlap: in_ready is 1 only in IDLE, so acceptance never coincides with the DONE→IDLE transition.
- Boundary case CHUNK=WIDTH: a single RUN cycle, out_valid one cycle after accept.
- Boundary case CHUNK=1: a pure bit-serial adder with WIDTH RUN cycles.
- Reset mid-operation (RUN or DONE): the operation is aborted and all outputs return to their reset values immediately. No partial result is ever presented with out_valid=1.

Test Plan:
- Use WIDTH=16, CHUNK=4 unless stated.
- Add with carry out: a=0xFFFF, b=0x0001, sub=0 → after 4 cycles out_valid=1, sum=0x0000, carry_out=1, overflow=0.
- Signed overflow on add: a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, carry_out=0, overflow=1.
- Subtract with borrow and with signed overflow:
  - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, carry_out=0, overflow=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, carry_out=1, overflow=1.
- Backpressure and input isolation:
  - Hold out_ready=0 for 3 cycles after out_valid rises. sum, flags and out_valid must stay stable and in_ready must stay 0.
  - Toggle a, b and in_valid during RUN; the result must be unaffected.
  - Raise out_ready; one cycle later in_ready=1.
- Reset mid-run: pull rst_n low at the second RUN cycle of 0x1234+0x1111. Outputs go to 0 asynchronously. After release, 0x1234+0x1111 gives sum=0x2345 with no spurious out_valid pulse.
- Parameter sweep with random operands, checked against a reference model (sum, carry_out, overflow, latency=NCHUNK):
  - WIDTH=5, CHUNK=5: 1-cycle latency; a=0x1F, b=0x01 → sum=0x00, carry_out=1.
  - WIDTH=32, CHUNK=1.
  - WIDTH=32, CHUNK=8.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: one CHUNK-bit ripple stage reused over
// WIDTH/CHUNK cycles, with the carry held in a register between cycles.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int NSLOT  = 1 << KW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [KW-1:0]     k_q, k_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic              running;
    logic              last_chunk;
    logic [CHUNK-1:0]  a_cur;
    logic [CHUNK-1:0]  b_cur;
    logic [CHUNK:0]    chunk_res;

    // Slot table padded to a power of two so k_q can index it directly.
    logic [CHUNK-1:0]  a_slots [NSLOT];
    logic [CHUNK-1:0]  b_slots [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NCHUNK) begin : g_used
                assign a_slots[gi] = a_q[gi*CHUNK +: CHUNK];
                assign b_slots[gi] = b_q[gi*CHUNK +: CHUNK];
            end else begin : g_pad
                assign a_slots[gi] = '0;
                assign b_slots[gi] = '0;
            end
        end
    endgenerate

    assign accept     = (state_q == IDLE) && in_valid;
    assign running    = (state_q == RUN);
    assign last_chunk = (k_q == KW'(NCHUNK - 1));
    assign a_cur      = a_slots[k_q];
    assign b_cur      = b_slots[k_q];
    assign chunk_res  = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, carry_q};

    // Only the chunk selected by k_q is rewritten; the rest hold.
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_sum
            assign sum_d[gi*CHUNK +: CHUNK] =
                (running && (k_q == KW'(gi))) ? chunk_res[CHUNK-1:0]
                                              : sum_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = a;
            b_d     = b ^ {WIDTH{sub}};
            carry_d = sub;
            k_d     = '0;
        end else if (running) begin
            carry_d = chunk_res[CHUNK];
            if (last_chunk) begin
                cout_d = chunk_res[CHUNK];
                // Same-sign operands producing a different-sign result.
                ovf_d  = (a_cur[CHUNK-1] == b_cur[CHUNK-1]) &&
                         (chunk_res[CHUNK-1] != a_cur[CHUNK-1]);
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: four parameterisations driven from one sequence,
// expected results queued at accept time and compared when out_valid rises.
module tb_seq_chunk_adder;

    localparam int NI = 4;
    localparam int WID [NI] = '{16, 5, 32, 32};
    localparam int NCH [NI] = '{4, 1, 32, 4};

    logic clk;
    logic rst_n;

    logic [31:0] a_v [NI];
    logic [31:0] b_v [NI];
    logic        sub_v [NI];
    logic        in_valid_v [NI];
    logic        out_ready_v [NI];

    logic [31:0] sum_v [NI];
    logic        in_ready_v [NI];
    logic        out_valid_v [NI];
    logic        cout_v [NI];
    logic        ovf_v [NI];

    wire [15:0] sum0;
    wire [4:0]  sum1;
    wire [31:0] sum2;
    wire [31:0] sum3;

    assign sum_v[0] = {16'b0, sum0};
    assign sum_v[1] = {27'b0, sum1};
    assign sum_v[2] = sum2;
    assign sum_v[3] = sum3;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0][15:0]), .b(b_v[0][15:0]), .sub(sub_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .sum(sum0), .carry_out(cout_v[0]), .overflow(ovf_v[0]));

    seq_chunk_adder #(.WIDTH(5), .CHUNK(5)) u_w5c5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][4:0]), .b(b_v[1][4:0]), .sub(sub_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .sum(sum1), .carry_out(cout_v[1]), .overflow(ovf_v[1]));

    seq_chunk_adder #(.WIDTH(32), .CHUNK(1)) u_w32c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .sub(sub_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .sum(sum2), .carry_out(cout_v[2]), .overflow(ovf_v[2]));

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_w32c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .a(a_v[3]), .b(b_v[3]), .sub(sub_v[3]),
        .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
        .sum(sum3), .carry_out(cout_v[3]), .overflow(ovf_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference from arithmetic definitions: unsigned compare for carry/borrow,
    // signed range test for overflow.
    function automatic exp_t model(input int idx, input logic [31:0] a, input logic [31:0] b,
                                   input logic s);
        exp_t        e;
        int          w;
        longint      ua, ub, sa, sb_, res, mask;
        w    = WID[idx];
        mask = (64'sd1 <<< w) - 1;
        ua   = longint'({32'b0, a}) & mask;
        ub   = longint'({32'b0, b}) & mask;
        sa   = (ua >= (64'sd1 <<< (w - 1))) ? ua - (64'sd1 <<< w) : ua;
        sb_  = (ub >= (64'sd1 <<< (w - 1))) ? ub - (64'sd1 <<< w) : ub;
        res  = s ? (sa - sb_) : (sa + sb_);
        e.idx  = idx;
        e.sum  = 32'((s ? (ua - ub) : (ua + ub)) & mask);
        e.cout = s ? (ua >= ub) : ((ua + ub) > mask);
        e.ovf  = (res > ((64'sd1 <<< (w - 1)) - 1)) || (res < -(64'sd1 <<< (w - 1)));
        return e;
    endfunction

    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int hold);
        exp_t        e;
        int          n;
        logic [31:0] held_sum;
        chk($sformatf("in_ready_idle[%0d]", idx), 32'(in_ready_v[idx]), 32'd1);
        a_v[idx]         = a;
        b_v[idx]         = b;
        sub_v[idx]       = s;
        in_valid_v[idx]  = 1'b1;
        out_ready_v[idx] = 1'b0;
        sb.push_back(model(idx, a, b, s));
        @(negedge clk);
        in_valid_v[idx] = 1'b0;
        n = 0;
        while (!out_valid_v[idx] && n < 64) begin
            chk($sformatf("in_ready_run[%0d]", idx), 32'(in_ready_v[idx]), 32'd0);
            // Operand and in_valid churn that must not disturb the running op.
            a_v[idx]        = $urandom;
            b_v[idx]        = $urandom;
            sub_v[idx]      = 1'($urandom_range(0, 1));
            in_valid_v[idx] = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        in_valid_v[idx] = 1'b0;
        chk($sformatf("latency[%0d]", idx), 32'(n), 32'(NCH[idx]));
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("sum[%0d]", idx), sum_v[idx], e.sum);
            chk($sformatf("carry_out[%0d]", idx), 32'(cout_v[idx]), 32'(e.cout));
            chk($sformatf("overflow[%0d]", idx), 32'(ovf_v[idx]), 32'(e.ovf));
            $display("op inst=%0d a=%h b=%h sub=%0d sum=%h cout=%0d ovf=%0d lat=%0d",
                     idx, a, b, s, sum_v[idx], cout_v[idx], ovf_v[idx], n);
        end
        held_sum = sum_v[idx];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk($sformatf("hold_valid[%0d]", idx), 32'(out_valid_v[idx]), 32'd1);
            chk($sformatf("hold_in_ready[%0d]", idx), 32'(in_ready_v[idx]), 32'd0);
            chk($sformatf("hold_sum[%0d]", idx), sum_v[idx], held_sum);
        end
        out_ready_v[idx] = 1'b1;
        @(negedge clk);
        out_ready_v[idx] = 1'b0;
        chk($sformatf("drain_valid[%0d]", idx), 32'(out_valid_v[idx]), 32'd0);
        chk($sformatf("drain_in_ready[%0d]", idx), 32'(in_ready_v[idx]), 32'd1);
        chk($sformatf("retain_sum[%0d]", idx), sum_v[idx], held_sum);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            a_v[i] = '0; b_v[i] = '0; sub_v[i] = 1'b0;
            in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_in_ready[%0d]", i), 32'(in_ready_v[i]), 32'd1);
            chk($sformatf("rst_out_valid[%0d]", i), 32'(out_valid_v[i]), 32'd0);
            chk($sformatf("rst_sum[%0d]", i), sum_v[i], 32'd0);
            chk($sformatf("rst_flags[%0d]", i), 32'({cout_v[i], ovf_v[i]}), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(0, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 0);
        run_op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 0);
        run_op(0, 32'h0000_8000, 32'h0000_0001, 1'b1, 3);

        // Abort 0x1234+0x1111 during its second RUN cycle.
        a_v[0] = 32'h1234; b_v[0] = 32'h1111; sub_v[0] = 1'b0; in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid_v[0]), 32'd0);
        chk("midrst_in_ready", 32'(in_ready_v[0]), 32'd1);
        chk("midrst_sum", sum_v[0], 32'd0);
        chk("midrst_flags", 32'({cout_v[0], ovf_v[0]}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(out_valid_v[0]), 32'd0);
        end
        run_op(0, 32'h0000_1234, 32'h0000_1111, 1'b0, 0);
        chk("post_rst_sum_const", sum_v[0], 32'h0000_2345);

        run_op(1, 32'h0000_001F, 32'h0000_0001, 1'b0, 1);
        chk("w5_sum_const", sum_v[1], 32'h0);
        chk("w5_cout_const", 32'(cout_v[1]), 32'd1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NI; i++) begin
                run_op(i, $urandom, $urandom, 1'($urandom_range(0, 1)), r % 2);
            end
        end
        run_op(2, 32'h8000_0000, 32'h0000_0001, 1'b1, 0);
        run_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(3, 32'h0000_0000, 32'h0000_0000, 1'b1, 0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
